// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the two-digit seven-segment scanner.
// All segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_D0   = 2'd0,
      S_GAP0 = 2'd1,
      S_D1   = 2'd2,
      S_GAP1 = 2'd3
   } state_e;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // Entry i holds the pattern for decimal digit i.
   localparam logic [9:0][6:0] SEG_DIG = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD to active-low seven-segment encoder.
// Non-decimal codes (10-15) render as a dash.
module seg7_enc
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (bcd < 4'd10) begin
         seg = SEG_DIG[bcd];
      end
   end

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed common-anode display driver with inter-digit blanking.
// Optional leading-zero blanking of the tens digit: define SEG7_SCAN_LZB_EN.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIGIT_CYC = 50000,
   parameter int GAP_CYC   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d_0,
   input  logic [3:0] d_1,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_tick
);

   localparam int MAX_CYC = (DIGIT_CYC > GAP_CYC) ? DIGIT_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2((MAX_CYC < 2) ? 2 : MAX_CYC);
   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
   localparam bit NO_GAP = (GAP_CYC == 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       dig0_q, dig0_d;
   logic [3:0]       dig1_q, dig1_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             tick_q, tick_d;

   logic             last;
   logic             enter_d0;
   logic [3:0]       enc_in;
   logic [6:0]       enc_seg;

   seg7_enc u_enc (
      .bcd (enc_in),
      .seg (enc_seg)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      last     = 1'b0;
      enter_d0 = 1'b0;
      dig0_d   = dig0_q;
      dig1_d   = dig1_q;
      enc_in   = dig1_q;
      seg_d    = SEG_OFF;
      an_d     = 2'b11;
      tick_d   = 1'b0;

      if (state_q == S_D0 || state_q == S_D1) begin
         last = (cnt_q == DIG_LAST);
      end else begin
         last = NO_GAP || (cnt_q == GAP_LAST);
      end

      if (last) begin
         cnt_d = '0;
         case (state_q)
            S_D0:    state_d = NO_GAP ? S_D1 : S_GAP0;
            S_GAP0:  state_d = S_D1;
            S_D1:    state_d = NO_GAP ? S_D0 : S_GAP1;
            S_GAP1:  state_d = S_D0;
            default: state_d = S_GAP1;
         endcase
      end

      // Digits are captured on the edge entering S_D0, and that same edge
      // already displays the freshly captured units value.
      enter_d0 = (state_d == S_D0) && (state_q != S_D0);
      if (enter_d0) begin
         dig0_d = d_0;
         dig1_d = d_1;
      end
      tick_d = enter_d0;
      enc_in = (state_d == S_D0) ? dig0_d : dig1_d;

      case (state_d)
         S_D0: begin
            an_d  = 2'b10;
            seg_d = enc_seg;
         end
         S_D1: begin
`ifdef SEG7_SCAN_LZB_EN
            if (dig1_d != 4'd0) begin
               an_d  = 2'b01;
               seg_d = enc_seg;
            end
`else
            an_d  = 2'b01;
            seg_d = enc_seg;
`endif
         end
         default: begin
            an_d  = 2'b11;
            seg_d = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_GAP1;
         cnt_q   <= '0;
         dig0_q  <= 4'd0;
         dig1_q  <= 4'd0;
         seg_q   <= SEG_OFF;
         an_q    <= 2'b11;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig0_q  <= dig0_d;
         dig1_q  <= dig1_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         tick_q  <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a DIGIT_CYC=4/GAP_CYC=2 instance and a gapless instance
// driven from the same clock, reset and digit inputs.
module tb_seg7_scan;

   logic       clk;
   logic       rst;
   logic [3:0] d_0;
   logic [3:0] d_1;
   logic [6:0] seg, seg_ng;
   logic [1:0] an, an_ng;
   logic       frame_tick, tick_ng;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic [1:0] an;
      logic       tick;
   } exp_t;

   exp_t exp_q[$];

   int         ng_pos = -1;
   logic [3:0] ng_d0  = 4'd0;
   logic [3:0] ng_d1  = 4'd0;

   seg7_scan #(.DIGIT_CYC(4), .GAP_CYC(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .d_0        (d_0),
      .d_1        (d_1),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   seg7_scan #(.DIGIT_CYC(4), .GAP_CYC(0)) u_dut_ng (
      .clk        (clk),
      .rst        (rst),
      .d_0        (d_0),
      .d_1        (d_1),
      .seg        (seg_ng),
      .an         (an_ng),
      .frame_tick (tick_ng)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic bit tens_blank(input logic [3:0] v);
`ifdef SEG7_SCAN_LZB_EN
      return (v == 4'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic push(input logic [6:0] s, input logic [1:0] a, input logic t);
      exp_t e;
      e.seg  = s;
      e.an   = a;
      e.tick = t;
      exp_q.push_back(e);
   endtask

   task automatic push_gap(input int n);
      for (int i = 0; i < n; i++) push(7'h7F, 2'b11, 1'b0);
   endtask

   task automatic push_frame(input logic [3:0] v0, input logic [3:0] v1);
      for (int i = 0; i < 4; i++) push(enc(v0), 2'b10, (i == 0));
      push_gap(2);
      for (int i = 0; i < 4; i++) begin
         if (tens_blank(v1)) push(7'h7F, 2'b11, 1'b0);
         else                push(enc(v1), 2'b01, 1'b0);
      end
      push_gap(2);
   endtask

   // Advance one clock, then compare both instances against their expectations.
   task automatic cycle();
      exp_t       e;
      logic [6:0] ng_seg;
      logic [1:0] ng_an;
      @(negedge clk);
      if (!rst) begin
         ng_pos = -1;
      end else begin
         ng_pos = (ng_pos == 7) ? 0 : ng_pos + 1;
         if (ng_pos == 0) begin
            ng_d0 = d_0;
            ng_d1 = d_1;
         end
      end
      if (ng_pos < 0) begin
         ng_seg = 7'h7F; ng_an = 2'b11;
      end else if (ng_pos < 4) begin
         ng_seg = enc(ng_d0); ng_an = 2'b10;
      end else if (tens_blank(ng_d1)) begin
         ng_seg = 7'h7F; ng_an = 2'b11;
      end else begin
         ng_seg = enc(ng_d1); ng_an = 2'b01;
      end
      chk("ng_an",   32'(an_ng),   32'(ng_an));
      chk("ng_seg",  32'(seg_ng),  32'(ng_seg));
      chk("ng_tick", 32'(tick_ng), 32'(ng_pos == 0));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("seg",  32'(seg),        32'(e.seg));
         chk("an",   32'(an),         32'(e.an));
         chk("tick", 32'(frame_tick), 32'(e.tick));
      end
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      rst = 1'b0;
      d_0 = 4'd3;
      d_1 = 4'd7;

      // Reset state
      push_gap(2);
      run(2);
      rst = 1'b1;

      // First frames after release; d_0 changes mid-D1 and mid-D0
      push_gap(1);
      push_frame(4'd3, 4'd7);
      run(9);
      d_0 = 4'd9;
      run(4);
      push_frame(4'd9, 4'd7);
      run(2);
      d_0 = 4'd5;
      run(6);
      d_0 = 4'd0;
      d_1 = 4'hC;
      run(4);
      push_frame(4'd0, 4'hC);
      run(12);

      // Reset asserted two cycles into S_D0
      push(7'h40, 2'b10, 1'b1);
      push(7'h40, 2'b10, 1'b0);
      run(2);
      rst = 1'b0;
      d_0 = 4'd3;
      d_1 = 4'd7;
      push_gap(1);
      run(1);
      rst = 1'b1;
      push_gap(1);
      push_frame(4'd3, 4'd7);
      run(13);

      // Zero and one in the tens position
      d_0 = 4'd5;
      d_1 = 4'd0;
      push_frame(4'd5, 4'd0);
      run(12);
      d_1 = 4'd1;
      push_frame(4'd5, 4'd1);
      run(12);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
